// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the SRAM slave FSM state type and a byte-lane merge helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RDWAIT = 2'b01,
        ST_ERR1   = 2'b10,
        ST_ERR2   = 2'b11
    } sram_state_e;

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Little-endian AHB byte-lane decoder with alignment check; oversize transfers enable no lanes.
module ahb_byte_lane_dec
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] lanes,
    output logic       misaligned
);

    // Lane enables and misalignment for one transfer
    always_comb begin
        lanes      = 4'b0000;
        misaligned = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                lanes      = 4'b0001 << addr_lo;
                misaligned = 1'b0;
            end
            HSIZE_HALF: begin
                lanes      = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            HSIZE_WORD: begin
                lanes      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                lanes      = 4'b0000;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite on-chip SRAM slave with read wait states, write-to-read forwarding
// and an ERROR response for out-of-range, misaligned, oversize or protected accesses.
module ahb_sram_ctrl
    import ahb_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 14,
    parameter int    WAIT_STATES = 0,
    parameter int    WP_WORDS    = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         IDX_W   = ADDR_WIDTH - 2;
    localparam int         DEPTH   = 1 << IDX_W;
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [31:0]      mem_r [DEPTH];
    sram_state_e      state_r, state_nxt_s;
    logic [2:0]       wait_cnt_r, wait_cnt_nxt_s;
    logic             pend_wr_r;
    logic [IDX_W-1:0] wr_idx_r, rd_idx_r;
    logic [3:0]       wr_lanes_r;
    logic             hreadyout_r, hresp_r;
    logic [31:0]      hrdata_r;

    logic [IDX_W-1:0] idx_s;
    logic [3:0]       lanes_s;
    logic             misaligned_s, oversize_s, range_err_s, wp_err_s, bad_s;
    logic             accept_s, wr_go_s, rd_go_s, wr_commit_s, fwd_hit_s, rd_done_s;
    logic [31:0]      rd_word_s;
    logic             unused_s;

    // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY
    assign unused_s = HTRANS[0];

    ahb_byte_lane_dec u_lane_dec (
        .hsize      (HSIZE),
        .addr_lo    (HADDR[1:0]),
        .lanes      (lanes_s),
        .misaligned (misaligned_s)
    );

    assign idx_s       = HADDR[ADDR_WIDTH-1:2];
    assign oversize_s  = (HSIZE > HSIZE_WORD);
    assign range_err_s = ((HADDR >> ADDR_WIDTH) != 32'd0);

    generate
        if (WP_WORDS > 0) begin : g_wp
            assign wp_err_s = HWRITE && ({{(32-IDX_W){1'b0}}, idx_s} < 32'(WP_WORDS));
        end else begin : g_no_wp
            assign wp_err_s = 1'b0;
        end
    endgenerate

    assign bad_s    = range_err_s | oversize_s | misaligned_s | wp_err_s;
    assign accept_s = HSEL && HREADY && HTRANS[1] && ((state_r == ST_IDLE) || (state_r == ST_ERR2));
    assign wr_go_s  = accept_s && !bad_s && HWRITE;
    assign rd_go_s  = accept_s && !bad_s && !HWRITE;

    // A pending write lands at the end of its data phase; a read of the same word
    // on that edge sees the merged value so the master never gets stale data.
    assign wr_commit_s = pend_wr_r && HREADY;
    assign fwd_hit_s   = wr_commit_s && (wr_idx_r == idx_s);
    assign rd_word_s   = fwd_hit_s ? lane_merge(mem_r[idx_s], HWDATA, wr_lanes_r) : mem_r[idx_s];
    assign rd_done_s   = (state_r == ST_RDWAIT) && (wait_cnt_r == 3'd0);

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (accept_s && bad_s) begin
                    state_nxt_s = ST_ERR1;
                end else if (rd_go_s && (WAIT_STATES > 0)) begin
                    state_nxt_s    = ST_RDWAIT;
                    wait_cnt_nxt_s = WS_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RDWAIT: begin
                if (wait_cnt_r == 3'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r - 3'd1;
                end
            end
            ST_ERR1: begin
                state_nxt_s = ST_ERR2;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                wait_cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // State register with handshake outputs decoded from the next state
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 3'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            hreadyout_r <= (state_nxt_s != ST_RDWAIT) && (state_nxt_s != ST_ERR1);
            hresp_r     <= ((state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    // Address-phase capture of write target and read index
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_wr_r  <= 1'b0;
            wr_idx_r   <= {IDX_W{1'b0}};
            wr_lanes_r <= 4'b0000;
            rd_idx_r   <= {IDX_W{1'b0}};
        end else begin
            if (wr_go_s) begin
                pend_wr_r  <= 1'b1;
                wr_idx_r   <= idx_s;
                wr_lanes_r <= lanes_s;
            end else if (HREADY) begin
                pend_wr_r  <= 1'b0;
            end else begin
                pend_wr_r  <= pend_wr_r;
            end
            if (rd_go_s) begin
                rd_idx_r <= idx_s;
            end else begin
                rd_idx_r <= rd_idx_r;
            end
        end
    end

    // Read data register: loaded on accept without wait states, else at the end of RDWAIT
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hrdata_r <= 32'd0;
        end else if (rd_go_s && (WAIT_STATES == 0)) begin
            hrdata_r <= rd_word_s;
        end else if (rd_done_s) begin
            hrdata_r <= mem_r[rd_idx_r];
        end else begin
            hrdata_r <= hrdata_r;
        end
    end

    // Memory array write port; contents survive reset
    always_ff @(posedge HCLK) begin
        if (wr_commit_s) begin
            mem_r[wr_idx_r] <= lane_merge(mem_r[wr_idx_r], HWDATA, wr_lanes_r);
        end
    end

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = hrdata_r;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Scoreboard bench for ahb_sram_ctrl: three instances (0, 3 and 2 read wait states)
// share one AHB master; expected responses are queued at issue and checked at data-phase end.
`timescale 1ns/1ps
module tb_ahb_sram_ctrl;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        rst_ab, rst_c;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    int          cur;

    logic        rdy0, rdy1, rdy2, resp0, resp1, resp2;
    logic [31:0] rdat0, rdat1, rdat2;
    logic        rdy_sel, resp_sel;
    logic [31:0] rdat_sel;

    int ws_of [3] = '{0, 3, 2};
    int wp_of [3] = '{4, 0, 0};

    typedef struct {
        string       tag;
        int          low;
        bit          resp;
        bit          chk_data;
        logic [31:0] data;
        bit          cap;
        int          key;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] mdl [int];
    logic [31:0] last_rd [3] = '{32'd0, 32'd0, 32'd0};
    int          n_tests = 0;
    int          n_fail  = 0;
    int          low_cnt = 0;
    bit          resp_low = 1'b0;

    ahb_sram_ctrl #(.ADDR_WIDTH(14), .WAIT_STATES(0), .WP_WORDS(4)) u_dut0 (
        .HCLK(HCLK), .HRESET(rst_ab), .HSEL(cur == 0), .HREADY(rdy0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdat0));

    ahb_sram_ctrl #(.ADDR_WIDTH(14), .WAIT_STATES(3), .WP_WORDS(0)) u_dut1 (
        .HCLK(HCLK), .HRESET(rst_ab), .HSEL(cur == 1), .HREADY(rdy1), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rdat1));

    ahb_sram_ctrl #(.ADDR_WIDTH(14), .WAIT_STATES(2), .WP_WORDS(0)) u_dut2 (
        .HCLK(HCLK), .HRESET(rst_c), .HSEL(cur == 2), .HREADY(rdy2), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdat2));

    always_comb begin
        case (cur)
            0:       begin rdy_sel = rdy0; resp_sel = resp0; rdat_sel = rdat0; end
            1:       begin rdy_sel = rdy1; resp_sel = resp1; rdat_sel = rdat1; end
            default: begin rdy_sel = rdy2; resp_sel = resp2; rdat_sel = rdat2; end
        endcase
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Data-phase monitor: counts wait cycles of the front transfer, checks it on completion
    always @(negedge HCLK) begin : p_mon
        exp_t e;
        if (sb_q.size() > 0) begin
            if (!rdy_sel) begin
                low_cnt++;
                if (resp_sel) resp_low = 1'b1;
            end else begin
                e = sb_q.pop_front();
                check_value({e.tag, "/wait"}, 32'(low_cnt), 32'(e.low));
                check_value({e.tag, "/resp"}, {31'd0, resp_sel}, {31'd0, e.resp});
                check_value({e.tag, "/resp_wait"}, {31'd0, resp_low},
                            {31'd0, (e.low > 0) ? e.resp : 1'b0});
                if (e.chk_data) check_value({e.tag, "/rdata"}, rdat_sel, e.data);
                if (e.cap) begin
                    mdl[e.key]   = rdat_sel;
                    last_rd[cur] = rdat_sel;
                end
                low_cnt  = 0;
                resp_low = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        htrans = 2'b00;
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Issue one NONSEQ transfer; returns one step after its accepting edge with HWDATA driven
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input string tag, input bit cap, input bit push);
        exp_t e;
        bit   bad;
        int   widx;
        int   n;
        widx  = int'(addr[13:2]);
        bad   = (addr >= 32'h0000_4000) || (size > 3'd2) || ((size == 3'd1) && addr[0]) ||
                ((size == 3'd2) && (addr[1:0] != 2'b00)) || (wr && (widx < wp_of[cur]));
        e.tag = tag;
        e.cap = cap;
        e.key = cur * 4096 + widx;
        if (bad) begin
            e.low = 1; e.resp = 1'b1; e.chk_data = !wr; e.data = last_rd[cur];
        end else if (wr) begin
            e.low = 0; e.resp = 1'b0; e.chk_data = 1'b0; e.data = 32'd0;
            if (push) begin
                logic [31:0] w;
                w = mdl.exists(e.key) ? mdl[e.key] : 32'd0;
                for (int i = 0; i < 4; i++) begin
                    if ((size == 3'd2) || ((size == 3'd1) && ((i / 2) == int'(addr[1]))) ||
                        ((size == 3'd0) && (i == int'(addr[1:0]))))
                        w[8*i +: 8] = wdata[8*i +: 8];
                end
                mdl[e.key] = w;
            end
        end else begin
            e.low = ws_of[cur]; e.resp = 1'b0; e.chk_data = !cap;
            e.data = mdl.exists(e.key) ? mdl[e.key] : 32'd0;
            if (push && !cap) last_rd[cur] = e.data;
        end
        haddr  = addr;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = size;
        n = 0;
        @(negedge HCLK);
        while (!rdy_sel && (n < 20)) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 20) check_value({tag, "/accept"}, {31'd0, rdy_sel}, 32'd1);
        @(posedge HCLK);
        #1;
        htrans = 2'b00;
        hwdata = wdata;
        if (push) sb_q.push_back(e);
    endtask

    initial begin
        int n;
        rst_ab = 1'b1; rst_c = 1'b1; cur = 0;
        haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = 32'd0;
        repeat (3) @(posedge HCLK);
        for (int i = 0; i < 3; i++) begin
            cur = i;
            @(negedge HCLK);
            check_value($sformatf("reset%0d/hreadyout", i), {31'd0, rdy_sel}, 32'd1);
            check_value($sformatf("reset%0d/hresp", i), {31'd0, resp_sel}, 32'd0);
            check_value($sformatf("reset%0d/hrdata", i), rdat_sel, 32'd0);
        end
        rst_ab = 1'b0; rst_c = 1'b0; cur = 0;
        @(posedge HCLK); #1;

        // Zero-wait instance with four protected words
        xfer(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, "w10", 1'b0, 1'b1);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, "r10", 1'b0, 1'b1);
        idle(2);
        xfer(1'b1, 32'h10, 3'd2, 32'h1122_3344, "w10b", 1'b0, 1'b1);
        idle(1);
        xfer(1'b1, 32'h13, 3'd0, 32'hAA00_0000, "wb13", 1'b0, 1'b1);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, "fwd_b13", 1'b0, 1'b1);
        xfer(1'b1, 32'h12, 3'd1, 32'hBEEF_0000, "wh12", 1'b0, 1'b1);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, "fwd_h12", 1'b0, 1'b1);
        xfer(1'b1, 32'h14, 3'd2, 32'h0102_0304, "w14", 1'b0, 1'b1);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, "nofwd10", 1'b0, 1'b1);
        xfer(1'b1, 32'h15, 3'd0, 32'h0000_7700, "wb15", 1'b0, 1'b1);
        idle(1);
        xfer(1'b0, 32'h14, 3'd2, 32'd0, "r14", 1'b0, 1'b1);
        xfer(1'b0, 32'h0000_4000, 3'd2, 32'd0, "err_range", 1'b0, 1'b1);
        xfer(1'b0, 32'h01, 3'd1, 32'd0, "err_half", 1'b0, 1'b1);
        xfer(1'b0, 32'h00, 3'd3, 32'd0, "err_size", 1'b0, 1'b1);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, "after_err", 1'b0, 1'b1);
        idle(2);
        xfer(1'b0, 32'h08, 3'd2, 32'd0, "r08_orig", 1'b1, 1'b1);
        idle(2);
        xfer(1'b1, 32'h08, 3'd2, 32'h1234_5678, "wp_w08", 1'b0, 1'b1);
        idle(1);
        xfer(1'b0, 32'h08, 3'd2, 32'd0, "wp_r08", 1'b0, 1'b1);
        xfer(1'b1, 32'h10, 3'd2, 32'h1234_5678, "wp_w10", 1'b0, 1'b1);
        xfer(1'b0, 32'h10, 3'd2, 32'd0, "wp_r10", 1'b0, 1'b1);
        xfer(1'b1, 32'h22, 3'd2, 32'hFFFF_FFFF, "err_wmis", 1'b0, 1'b1);
        xfer(1'b0, 32'h14, 3'd2, 32'd0, "r14_after", 1'b0, 1'b1);
        idle(3);

        // Three read wait states
        cur = 1;
        xfer(1'b1, 32'h20, 3'd2, 32'h0BAD_F00D, "ws3_w20", 1'b0, 1'b1);
        idle(1);
        xfer(1'b0, 32'h20, 3'd2, 32'd0, "ws3_r20", 1'b0, 1'b1);
        xfer(1'b1, 32'h24, 3'd2, 32'hA5A5_0F0F, "ws3_w24", 1'b0, 1'b1);
        xfer(1'b0, 32'h24, 3'd2, 32'd0, "ws3_r24", 1'b0, 1'b1);
        xfer(1'b0, 32'h0001_0000, 3'd2, 32'd0, "ws3_err", 1'b0, 1'b1);
        idle(3);

        // Two wait states, reset asserted in the middle of a read
        cur = 2;
        xfer(1'b1, 32'h30, 3'd2, 32'hCAFE_0001, "ws2_w30", 1'b0, 1'b1);
        xfer(1'b0, 32'h30, 3'd2, 32'd0, "ws2_r30", 1'b0, 1'b1);
        idle(4);
        xfer(1'b0, 32'h30, 3'd2, 32'd0, "ws2_abort", 1'b0, 1'b0);
        @(negedge HCLK);
        check_value("rst_mid/hreadyout_before", {31'd0, rdy_sel}, 32'd0);
        rst_c = 1'b1;
        #1;
        check_value("rst_mid/hreadyout", {31'd0, rdy_sel}, 32'd1);
        check_value("rst_mid/hresp", {31'd0, resp_sel}, 32'd0);
        check_value("rst_mid/hrdata", rdat_sel, 32'd0);
        last_rd[2] = 32'd0;
        @(negedge HCLK);
        rst_c = 1'b0;
        idle(2);
        xfer(1'b1, 32'h34, 3'd2, 32'h5A5A_0F0F, "ws2_w34", 1'b0, 1'b1);
        xfer(1'b0, 32'h34, 3'd2, 32'd0, "ws2_r34", 1'b0, 1'b1);
        xfer(1'b0, 32'h30, 3'd2, 32'd0, "ws2_r30_kept", 1'b0, 1'b1);
        idle(2);

        n = 0;
        while ((sb_q.size() > 0) && (n < 50)) begin
            @(posedge HCLK);
            n++;
        end
        if (sb_q.size() > 0) check_value("drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
